pattern_scan_sched: RTL and testbench

//  Round-robin scheduler that shares one bit-serial "1001" Moore detector between NREQ requesters.
//  - Grants one requester at a time and captures its WORD_W-bit word.
//  - Shifts the word MSB-first through the detector.
//  - Reports per word: match flag, position of first match, requester id.
//  - Sits between word-producing clients and the serial detector core.

---
 rtl/pscan_pkg.sv | 20 ++
 rtl/pscan_detect.sv | 38 +++
 rtl/pattern_scan_sched.sv | 145 ++++++++++++++
 tb/tb_pattern_scan_sched.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/pscan_pkg.sv
// rtl/pscan_pkg.sv - shared types and pattern constant for the pattern scan scheduler
package pscan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_REPORT = 2'd2
    } sched_state_t;

    typedef enum logic [2:0] {
        DS0 = 3'd0,
        DS1 = 3'd1,
        DS2 = 3'd2,
        DS3 = 3'd3,
        DS4 = 3'd4
    } det_state_t;

    localparam logic [3:0] PSCAN_PATTERN = 4'b1001;

endpackage

// File: rtl/pscan_detect.sv
// rtl/pscan_detect.sv - bit-serial Moore detector for PSCAN_PATTERN, sticky once matched
module pscan_detect
    import pscan_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    input  logic bit_in,
    output logic hit
);

    det_state_t st_q, st_d;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            st_q <= DS0;
        end else if (en) begin
            st_q <= st_d;
        end
    end

    // Mismatch fallbacks reuse any pattern prefix that the failing bit still forms
    always_comb begin
        st_d = st_q;
        case (st_q)
            DS0:     st_d = (bit_in == PSCAN_PATTERN[3]) ? DS1 : DS0;
            DS1:     st_d = (bit_in == PSCAN_PATTERN[2]) ? DS2 : DS1;
            DS2:     st_d = (bit_in == PSCAN_PATTERN[1]) ? DS3 : DS1;
            DS3:     st_d = (bit_in == PSCAN_PATTERN[0]) ? DS4 : DS0;
            DS4:     st_d = DS4;
            default: st_d = DS0;
        endcase
    end

    assign hit = (st_q == DS4);

endmodule

// File: rtl/pattern_scan_sched.sv
// rtl/pattern_scan_sched.sv - round-robin scheduler feeding requester words to one serial detector
// Optional saturating match counter port enabled by PSCAN_MATCH_CNT_EN.
module pattern_scan_sched
    import pscan_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int WORD_W = 8,
    parameter int IDW    = 2,
    parameter int POSW   = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*WORD_W-1:0]   word,
    output logic [NREQ-1:0]          gnt,
    output logic                     busy,
    output logic                     done,
    output logic [IDW-1:0]           done_id,
    output logic                     match,
    output logic [POSW-1:0]          match_pos
`ifdef PSCAN_MATCH_CNT_EN
    ,
    output logic [7:0]               match_cnt
`endif
);

    localparam int CNTW = POSW + 1;

    sched_state_t       st_q, st_d;
    logic [IDW-1:0]     rr_q, gid_q, win, cand;
    logic               win_vld;
    logic [WORD_W-1:0]  sh_q;
    logic [CNTW-1:0]    cnt_q;
    logic               found_q;
    logic [POSW-1:0]    pos_q;
    logic               hit, cap, shift_en;

    always_comb begin
        win     = '0;
        win_vld = 1'b0;
        cand    = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = IDW'((int'(rr_q) + i) % NREQ);
            if (!win_vld && req[cand]) begin
                win     = cand;
                win_vld = 1'b1;
            end
        end
    end

    assign cap      = (st_q == ST_IDLE) && win_vld;
    assign shift_en = (st_q == ST_SHIFT);

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q <= ST_IDLE;
        end else begin
            st_q <= st_d;
        end
    end

    always_comb begin
        st_d = st_q;
        case (st_q)
            ST_IDLE:   if (win_vld) st_d = ST_SHIFT;
            ST_SHIFT:  if (cnt_q == CNTW'(WORD_W - 1)) st_d = ST_REPORT;
            ST_REPORT: st_d = ST_IDLE;
            default:   st_d = ST_IDLE;
        endcase
    end

    // hit is seen one cycle after the detector enters S4, so the bit index is cnt_q-1
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q    <= '0;
            gid_q   <= '0;
            sh_q    <= '0;
            cnt_q   <= '0;
            found_q <= 1'b0;
            pos_q   <= '0;
        end else if (cap) begin
            sh_q    <= word[win*WORD_W +: WORD_W];
            gid_q   <= win;
            rr_q    <= (win == IDW'(NREQ - 1)) ? '0 : win + 1'b1;
            cnt_q   <= '0;
            found_q <= 1'b0;
            pos_q   <= '0;
        end else if (shift_en) begin
            sh_q  <= {sh_q[WORD_W-2:0], 1'b0};
            cnt_q <= cnt_q + 1'b1;
            if (hit && !found_q) begin
                found_q <= 1'b1;
                pos_q   <= POSW'(cnt_q - 1'b1);
            end
        end
    end

    pscan_detect u_detect (
        .clk    (clk),
        .rst    (rst),
        .clr    (cap),
        .en     (shift_en),
        .bit_in (sh_q[WORD_W-1]),
        .hit    (hit)
    );

    // A match completed by the last bit is only visible in REPORT, hence the WORD_W-1 fallback
    always_comb begin
        gnt       = '0;
        busy      = 1'b0;
        done      = 1'b0;
        done_id   = '0;
        match     = 1'b0;
        match_pos = '0;
        case (st_q)
            ST_SHIFT: begin
                busy = 1'b1;
                if (cnt_q == '0) gnt = NREQ'(1) << gid_q;
            end
            ST_REPORT: begin
                busy      = 1'b1;
                done      = 1'b1;
                done_id   = gid_q;
                match     = hit;
                match_pos = !hit ? '0 : (found_q ? pos_q : POSW'(WORD_W - 1));
            end
            default: ;
        endcase
    end

`ifdef PSCAN_MATCH_CNT_EN
    logic [7:0] mcnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            mcnt_q <= '0;
        end else if ((st_q == ST_REPORT) && hit && (mcnt_q != 8'hFF)) begin
            mcnt_q <= mcnt_q + 1'b1;
        end
    end

    assign match_cnt = mcnt_q;
`endif

endmodule

// File: tb/tb_pattern_scan_sched.sv
// tb/tb_pattern_scan_sched.sv - directed self-checking bench for pattern_scan_sched
module tb_pattern_scan_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] word;
    logic [3:0]  gnt;
    logic        busy, done, match;
    logic [1:0]  done_id;
    logic [2:0]  match_pos;
`ifdef PSCAN_MATCH_CNT_EN
    logic [7:0]  match_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pattern_scan_sched #(.NREQ(4), .WORD_W(8), .IDW(2), .POSW(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .word      (word),
        .gnt       (gnt),
        .busy      (busy),
        .done      (done),
        .done_id   (done_id),
        .match     (match),
        .match_pos (match_pos)
`ifdef PSCAN_MATCH_CNT_EN
        ,
        .match_cnt (match_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_gnt();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (gnt == 4'b0 && n < 40);
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 40);
    endtask

    // gnt is seen in the first SHIFT cycle; done follows WORD_W cycles later
    task automatic run(input logic [3:0] rq, input logic [31:0] wv, input int exp_id,
                       input logic exp_m, input logic [2:0] exp_p);
        int lat;
        req  = rq;
        word = wv;
        wait_gnt();
        check("gnt", gnt, 32'd1 << exp_id);
        req = 4'b0;
        wait_done(lat);
        check("latency", lat, 8);
        check("done_id", done_id, exp_id);
        check("match", match, exp_m);
        check("match_pos", match_pos, exp_p);
        @(negedge clk);
        check("done_pulse", done, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int last, lat, ndone;
        rst  = 1'b1;
        req  = 4'b1111;
        word = 32'h9090_9090;
        repeat (3) @(negedge clk);
        check("rst_gnt", gnt, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_done_id", done_id, 0);
        check("rst_match", match, 0);
        check("rst_match_pos", match_pos, 0);
        rst = 1'b0;
        req = 4'b0;
        repeat (4) @(negedge clk);
        check("idle_busy", busy, 0);
        check("idle_gnt", gnt, 0);

        run(4'b0001, 32'h0000_0090, 0, 1'b1, 3'd3);
        run(4'b0010, 32'h0000_8800, 1, 1'b0, 3'd0);
        run(4'b0100, 32'h0099_0000, 2, 1'b1, 3'd3);
        run(4'b1000, 32'h0900_0000, 3, 1'b1, 3'd7);
        run(4'b0001, 32'h0000_00D2, 0, 1'b1, 3'd6);
        run(4'b0010, 32'h0000_A500, 1, 1'b1, 3'd5);

        // all four requesting after reset: rr order from 0, 10 cycles per grant
        rst = 1'b1;
        @(negedge clk);
        rst  = 1'b0;
        word = 32'h0900_0000;
        req  = 4'b1111;
        last = 0;
        for (int k = 0; k < 4; k++) begin
            wait_gnt();
            check("rr_gnt", gnt, 32'd1 << k);
            if (k > 0) check("rr_spacing", cyc - last, 10);
            last   = cyc;
            req[k] = 1'b0;
            wait_done(lat);
            check("rr_done_id", done_id, k);
        end
        check("rr_last_match_pos", match_pos, 7);

        // abort mid-shift: rr_ptr is 3 before reset, so the lowest request must win afterwards
        run(4'b0010, 32'h0000_0000, 1, 1'b0, 3'd0);
        req  = 4'b0100;
        word = 32'h0090_0000;
        wait_gnt();
        check("abort_gnt", gnt, 4'b0100);
        req = 4'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("abort_no_done", ndone, 0);
        run(4'b1010, 32'h9900_4800, 1, 1'b1, 3'd4);

`ifdef PSCAN_MATCH_CNT_EN
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mcnt_reset", match_cnt, 0);
        for (int i = 0; i < 300; i++) run(4'b0001, 32'h0000_0090, 0, 1'b1, 3'd3);
        check("mcnt_sat", match_cnt, 255);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mcnt_clear", match_cnt, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
